// File: rtl/bidir_bus_ctrl_pkg.sv
// Shared definitions for the half-duplex bus controller: state encoding,
// bus direction values and synchroniser depth.
package bidir_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TURN_OUT = 3'd1,
        ST_WRITE    = 3'd2,
        ST_TURN_IN  = 3'd3,
        ST_RD_SYNC  = 3'd4,
        ST_RD_CAP   = 3'd5
    } state_t;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/bidir_bus_ctrl_io_sync2.sv
// Two-flop per-bit synchroniser for the asynchronous pad input.
module io_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Sequences single read/write commands onto a half-duplex tristate bus,
// inserting released-bus turnaround cycles on every direction change.
module bidir_bus_ctrl
    import bidir_bus_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_wr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_bus_dir,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    output logic                  o_bus_strobe,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

    // A zero-cycle turnaround still needs a one-bit counter to keep widths legal.
    localparam int CW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
    localparam int SW = $clog2(SYNC_DEPTH);

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         turn_cnt_q, turn_cnt_d;
    logic [SW-1:0]         sync_cnt_q, sync_cnt_d;
    logic [DATA_WIDTH-1:0] pad_sync;

    io_sync2 #(.WIDTH(DATA_WIDTH)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_bus_rdata),
        .o_q   (pad_sync)
    );

    // Handshake: a command transfers on a rising edge with i_cmd_valid & o_cmd_ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_IN;
            wdata_q    <= '0;
            rdata_q    <= '0;
            turn_cnt_q <= '0;
            sync_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            turn_cnt_q <= turn_cnt_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        turn_cnt_d = turn_cnt_q;
        sync_cnt_d = sync_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_wr) begin
                        wdata_d = i_cmd_wdata;
                        if (dir_q == DIR_OUT || TURN_CYCLES == 0) begin
                            state_d = ST_WRITE;
                            dir_d   = DIR_OUT;
                        end else begin
                            state_d    = ST_TURN_OUT;
                            turn_cnt_d = CW'(TURN_CYCLES);
                        end
                    end else begin
                        dir_d = DIR_IN;
                        if (dir_q == DIR_OUT && TURN_CYCLES > 0) begin
                            state_d    = ST_TURN_IN;
                            turn_cnt_d = CW'(TURN_CYCLES);
                        end else begin
                            state_d    = ST_RD_SYNC;
                            sync_cnt_d = SW'(SYNC_DEPTH - 1);
                        end
                    end
                end
            end
            ST_TURN_OUT: begin
                turn_cnt_d = turn_cnt_q - CW'(1);
                if (turn_cnt_q <= CW'(1)) begin
                    turn_cnt_d = '0;
                    state_d    = ST_WRITE;
                    dir_d      = DIR_OUT;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_TURN_IN: begin
                turn_cnt_d = turn_cnt_q - CW'(1);
                if (turn_cnt_q <= CW'(1)) begin
                    turn_cnt_d = '0;
                    state_d    = ST_RD_SYNC;
                    sync_cnt_d = SW'(SYNC_DEPTH - 1);
                end
            end
            ST_RD_SYNC: begin
                // Data is captured on entry to RD_CAP so it lines up with the response pulse.
                if (sync_cnt_q == '0) begin
                    state_d = ST_RD_CAP;
                    rdata_d = pad_sync;
                end else begin
                    sync_cnt_d = sync_cnt_q - SW'(1);
                end
            end
            ST_RD_CAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                dir_d   = DIR_IN;
            end
        endcase
    end

    assign o_cmd_ready  = (state_q == ST_IDLE);
    assign o_bus_strobe = (state_q == ST_WRITE);
    assign o_rsp_valid  = (state_q == ST_RD_CAP);
    assign o_bus_dir    = dir_q;
    assign o_bus_wdata  = wdata_q;
    assign o_rsp_rdata  = rdata_q;

endmodule
